// File: rtl/spi_slave.sv
// SPI mode-0 responder on the j1 system clock, with a UART-style rd/wr/valid/busy CPU handshake.
// Define SPI_SLAVE_OVERRUN_EN to build the sticky overrun flag (cleared by rd); otherwise it is tied 0.
`timescale 1ns/1ps
module spi_slave #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        sck,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic        rd,
   input  logic        wr,
   input  logic [7:0]  tx_data,
   output logic [7:0]  rx_data,
   output logic        valid,
   output logic        busy,
   output logic        overrun,
   output logic        active
);

   typedef enum logic {IDLE, SELECTED} state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_d, cs_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_fall, cs_rise;
   logic                   selected, complete, load_tx;
   logic [2:0]             bit_cnt;
   logic                   byte_done;
   logic [6:0]             rx_shift;
   logic [7:0]             tx_shift, hold, reload_byte;

   // Synchronisers reset to the idle bus (sck low, cs_n high) so release makes no false edge.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_s;
         cs_d      <= cs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_s & cs_d;
   assign cs_rise  = cs_s & ~cs_d;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      // NOTE: defaults first so no path through this block can infer a latch.
      state_next = state;
      selected   = 1'b0;
      case (state)
         IDLE:     if (cs_fall) state_next = SELECTED;
         SELECTED: begin
            selected = ~cs_rise;
            if (cs_rise) state_next = IDLE;
         end
         default:  state_next = IDLE;
      endcase
   end

   assign active      = selected;
   assign miso_oe     = selected;
   assign miso        = selected ? tx_shift[7] : 1'b1;
   assign reload_byte = busy ? hold : IDLE_BYTE;
   assign complete    = selected & sck_rise & (bit_cnt == 3'd7);
   // byte_done keeps the first falling edge after a select from reloading a fresh byte.
   assign load_tx     = ((state == IDLE) & cs_fall) |
                        (selected & sck_fall & (bit_cnt == 3'd0) & byte_done);

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         rx_shift  <= '0;
         tx_shift  <= '0;
      end else if (load_tx) begin
         tx_shift  <= reload_byte;
         byte_done <= 1'b0;
         if (state == IDLE) bit_cnt <= 3'd0;
      end else if (state == SELECTED && cs_rise) begin
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
      end else if (selected && sck_rise) begin
         rx_shift <= {rx_shift[5:0], mosi_s};
         bit_cnt  <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end else if (selected && sck_fall && bit_cnt != 3'd0) begin
         tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_data <= 8'h00;
         valid   <= 1'b0;
      end else if (complete) begin
         rx_data <= {rx_shift, mosi_s};
         valid   <= 1'b1;
      end else if (rd) begin
         valid   <= 1'b0;
      end
   end

   // A wr that lands on a reload is seen as busy=0 by the reload and held for the next boundary.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         busy <= 1'b0;
         hold <= 8'h00;
      end else if (wr && !busy) begin
         busy <= 1'b1;
         hold <= tx_data;
      end else if (load_tx && busy) begin
         busy <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic overrun_q;
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq)                     overrun_q <= 1'b0;
      else if (complete && valid && !rd) overrun_q <= 1'b1;
      else if (rd)                     overrun_q <= 1'b0;
   end
   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master drives directed bytes, a monitor checks rx results.
`timescale 1ns/1ps
module tb_spi_slave;

   localparam int SYNC_STAGES = 2;
`ifdef SPI_SLAVE_OVERRUN_EN
   localparam logic OVR_EN = 1'b1;
`else
   localparam logic OVR_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetq, sck, cs_n, mosi, rd, wr;
   logic [7:0] tx_data;
   logic       miso, miso_oe, valid, busy, overrun, active;
   logic [7:0] rx_data;

   int   checks = 0;
   int   errors = 0;
   exp_t rx_exp[$];
   time  last_rise = 0;

   spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .resetq(resetq), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rd(rd), .wr(wr), .tx_data(tx_data),
      .rx_data(rx_data), .valid(valid), .busy(busy), .overrun(overrun), .active(active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_wr(input logic [7:0] b);
      @(negedge clk); wr = 1'b1; tx_data = b;
      @(negedge clk); wr = 1'b0;
   endtask

   task automatic cpu_rd();
      @(negedge clk); rd = 1'b1;
      @(negedge clk); rd = 1'b0;
   endtask

   task automatic cs_low();  cs_n = 1'b0; cycles(8); endtask
   task automatic cs_high(); cs_n = 1'b1; cycles(8); endtask

   // One mode-0 bit at sck = clk/8; optional rd pulse straddles the clk edge that completes the byte.
   task automatic spi_bit(input logic b, input bit rd_end, output logic got);
      mosi = b;
      cycles(4);
      got = miso;
      sck = 1'b1;
      last_rise = $time;
      if (rd_end) begin
         cycles(2); rd = 1'b1;
         cycles(1); rd = 1'b0;
         cycles(1);
      end else begin
         cycles(4);
      end
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] m, input logic [7:0] exp_miso,
                           input logic exp_ovr, input bit rd_end);
      logic [7:0] got;
      logic       g;
      got = 8'h00;
      rx_exp.push_back('{data: m, ovr: exp_ovr});
      for (int i = 7; i >= 0; i--) begin
         spi_bit(m[i], rd_end && (i == 0), g);
         got[i] = g;
      end
      check("miso_byte", got, exp_miso);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_bit({tag, "_miso"}, miso, 1'b1);
      check_bit({tag, "_miso_oe"}, miso_oe, 1'b0);
      check({tag, "_rx_data"}, rx_data, 8'h00);
      check_bit({tag, "_valid"}, valid, 1'b0);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check_bit({tag, "_overrun"}, overrun, 1'b0);
      check_bit({tag, "_active"}, active, 1'b0);
   endtask

   // Monitor: a new received byte shows up as valid rising, or rx_data changing while valid stays high.
   initial begin
      logic       valid_q;
      logic [7:0] rx_q;
      exp_t       e;
      valid_q = 1'b0;
      rx_q    = 8'h00;
      forever begin
         @(negedge clk);
         if (!resetq) begin
            valid_q = 1'b0;
            rx_q    = 8'h00;
         end else begin
            if (valid && (!valid_q || rx_data != rx_q)) begin
               if (rx_exp.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rx_unexpected: got %h expected no byte at %0t", rx_data, $time);
               end else begin
                  e = rx_exp.pop_front();
                  check("rx_data", rx_data, e.data);
                  check_bit("rx_overrun", overrun, e.ovr);
                  check_bit("rx_latency", ($time - last_rise) <= (SYNC_STAGES + 1) * 10, 1'b1);
               end
            end
            valid_q = valid;
            rx_q    = rx_data;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic g;
      resetq = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      rd = 1'b0; wr = 1'b0; tx_data = 8'h00;
      cycles(4);
      check_reset_outputs("reset");
      resetq = 1'b1;
      cycles(4);

      // Queued A5 goes out while 3C comes in.
      cpu_wr(8'hA5);
      check_bit("busy_after_wr", busy, 1'b1);
      cs_low();
      check_bit("active_sel", active, 1'b1);
      check_bit("miso_oe_sel", miso_oe, 1'b1);
      check_bit("busy_after_cs", busy, 1'b0);
      spi_byte(8'h3C, 8'hA5, 1'b0, 1'b0);
      cs_high();
      check_bit("active_idle", active, 1'b0);
      check_bit("miso_oe_idle", miso_oe, 1'b0);
      check_bit("miso_idle", miso, 1'b1);
      check("rx_3c", rx_data, 8'h3C);
      cpu_rd();
      check_bit("valid_after_rd", valid, 1'b0);

      // Back-to-back unread bytes.
      cs_low();
      spi_byte(8'h11, 8'hFF, 1'b0, 1'b0);
      spi_byte(8'h22, 8'hFF, OVR_EN, 1'b0);
      cs_high();
      check("rx_22", rx_data, 8'h22);
      check_bit("overrun_set", overrun, OVR_EN);
      cpu_rd();
      check_bit("valid_cleared", valid, 1'b0);
      check_bit("overrun_cleared", overrun, 1'b0);

      // Abort after five bits, then a full byte.
      cs_low();
      for (int i = 7; i >= 3; i--) spi_bit(i >= 4, 1'b0, g);
      cs_high();
      check_bit("valid_after_abort", valid, 1'b0);
      check("rx_after_abort", rx_data, 8'h22);
      cs_low();
      spi_byte(8'h81, 8'hFF, 1'b0, 1'b0);
      cs_high();
      cpu_rd();

      // rd exactly at completion of a second byte.
      cs_low();
      spi_byte(8'h5A, 8'hFF, 1'b0, 1'b0);
      spi_byte(8'hC3, 8'hFF, 1'b0, 1'b1);
      cs_high();
      check_bit("valid_rd_coincide", valid, 1'b1);
      check("rx_c3", rx_data, 8'hC3);
      check_bit("overrun_rd_coincide", overrun, 1'b0);
      cpu_rd();

      // Second wr while busy is dropped.
      cpu_wr(8'h55);
      cpu_wr(8'hAA);
      check_bit("busy_held", busy, 1'b1);
      cs_low();
      spi_byte(8'h01, 8'h55, 1'b0, 1'b0);
      spi_byte(8'h02, 8'hFF, OVR_EN, 1'b0);
      cs_high();
      check_bit("busy_drained", busy, 1'b0);
      cpu_rd();
      check_bit("overrun_final_clear", overrun, 1'b0);

      // Reset in the middle of a transfer with a byte queued.
      cpu_wr(8'h77);
      cs_low();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, g);
      @(negedge clk); resetq = 1'b0;
      cycles(2);
      check_reset_outputs("midreset");
      cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      cycles(4);
      resetq = 1'b1;
      cycles(4);
      cs_low();
      spi_byte(8'h99, 8'hFF, 1'b0, 1'b0);
      cs_high();
      cpu_rd();

      cycles(10);
      check_bit("rx_queue_drained", rx_exp.size() == 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
